// File: rtl/bool_fn_checker_if.sv
// Stimulus/compare bus between bool_fn_checker (master) and its environment (slave).
// First-fail capture signals exist only when BOOL_CHK_FIRST_FAIL_EN is defined.
interface bool_fn_checker_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   fail_count;
`ifdef BOOL_CHK_FIRST_FAIL_EN
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_vec;

  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
  );
  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
  );
`else
  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, fail_count
  );
  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, fail_count
  );
`endif
endinterface

// File: rtl/bool_fn_checker.sv
// Exhaustive stimulus/compare engine for an N_IN-input Boolean block against TRUTH.
// Optional first-mismatch capture enabled by defining BOOL_CHK_FIRST_FAIL_EN.
module bool_fn_checker #(
  parameter int                   N_IN   = 3,
  parameter logic [2**N_IN-1:0]   TRUTH  = 8'hE8,
  parameter int                   SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bool_fn_checker_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t          state, state_nxt;
  logic [N_IN-1:0] vec;
  logic [3:0]      cnt;
  logic [N_IN:0]   fail_count;
  logic            pass_r;
  logic            accept, sample, last_vec, mismatch;

  assign accept   = (state == IDLE) && bus.start;
  assign sample   = (state == RUN) && (cnt == SETTLE_W);
  assign last_vec = (vec == '1);
  assign mismatch = sample && (bus.dut_out != TRUTH[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (sample && last_vec) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // pass is resolved on the final sampling edge so it is already valid in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      cnt        <= '0;
      fail_count <= '0;
      pass_r     <= 1'b0;
    end else if (accept) begin
      vec        <= '0;
      cnt        <= '0;
      fail_count <= '0;
      pass_r     <= 1'b0;
    end else if (state == RUN) begin
      if (sample) begin
        cnt <= '0;
        if (mismatch) fail_count <= fail_count + (N_IN+1)'(1);
        if (last_vec) pass_r <= (fail_count == '0) && !mismatch;
        else          vec    <= vec + N_IN'(1);
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign bus.dut_in     = vec;
  assign bus.pass       = pass_r;
  assign bus.fail_count = fail_count;

`ifdef BOOL_CHK_FIRST_FAIL_EN
  logic            ff_valid;
  logic [N_IN-1:0] ff_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
    end else if (accept) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
    end else if (mismatch && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_vec   <= vec;
    end
  end

  assign bus.first_fail_valid = ff_valid;
  assign bus.first_fail_vec   = ff_vec;
`endif

endmodule
